sort_sequencer: RTL and testbench

Sequential ascending sorter that time-shares a single unsigned greater-than comparator across a bubble-sort schedule. Accepts a frame of DEPTH words over a valid/ready input stream, sorts them in place with one comparison per cycle, then streams them out smallest-first over a valid/ready output stream. It is the controller that sequences the gate-level comparator datapath, so the comparator is exercised as a shared resource rather than replicated.

---
 rtl/sort_pkg.sv | 16 +
 rtl/greater_than_n_bit.sv | 12 +
 rtl/sort_sequencer.sv | 168 ++++++++++++++++
 tb/tb_sort_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for sort_sequencer: controller state encoding and the
// index-width helper used to size the word, pass and position counters.
package sort_pkg;

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        UNLOAD
    } state_t;

    // A two-entry frame still needs a 1-bit index.
    function automatic int idxWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/greater_than_n_bit.sv
// Unsigned magnitude comparator shared by the sort schedule: o_out = (i_a > i_b).
module greater_than_n_bit #(
    parameter int NUM_OF_BITS = 4
) (
    input  logic [NUM_OF_BITS-1:0] i_a,
    input  logic [NUM_OF_BITS-1:0] i_b,
    output logic                   o_out
);

    assign o_out = (i_a > i_b);

endmodule

// File: rtl/sort_sequencer.sv
// Frame sorter: loads DEPTH words, bubble-sorts them through one shared comparator,
// then streams them out smallest-first. Define SORT_EARLY_EXIT_EN to stop after a clean pass.
module sort_sequencer
    import sort_pkg::*;
#(
    parameter int NUM_OF_BITS = 4,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_OF_BITS-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_OF_BITS-1:0] out_data,
    output logic                   busy
);

    localparam int            IW        = idxWidth(DEPTH);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST_PASS = IW'(DEPTH - 2);

    state_t                 r_state;
    state_t                 w_nextState;
    logic [NUM_OF_BITS-1:0] r_mem [DEPTH];
    logic [IW-1:0]          r_wrIdx;
    logic [IW-1:0]          r_rdIdx;
    logic [IW-1:0]          r_pass;
    logic [IW-1:0]          r_pos;
    logic                   r_swapped;

    logic [IW-1:0]          w_posNext;
    logic [NUM_OF_BITS-1:0] w_a;
    logic [NUM_OF_BITS-1:0] w_b;
    logic                   w_swap;
    logic                   w_lastPos;
    logic                   w_sortDone;
    logic                   w_inFire;
    logic                   w_outFire;

    assign w_posNext = r_pos + 1'b1;
    assign w_a       = r_mem[r_pos];
    assign w_b       = r_mem[w_posNext];
    assign w_lastPos = (r_pos == (LAST_PASS - r_pass));

    greater_than_n_bit #(
        .NUM_OF_BITS(NUM_OF_BITS)
    ) u_gt (
        .i_a  (w_a),
        .i_b  (w_b),
        .o_out(w_swap)
    );

    // Early exit counts the compare happening this cycle as part of the pass.
    always_comb begin
        w_sortDone = (r_pass == LAST_PASS);
`ifdef SORT_EARLY_EXIT_EN
        if (!r_swapped && !w_swap) begin
            w_sortDone = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        busy        = 1'b0;
        w_inFire    = 1'b0;
        w_outFire   = 1'b0;
        case (r_state)
            LOAD: begin
                in_ready = 1'b1;
                w_inFire = in_valid;
                if (in_valid && (r_wrIdx == LAST_IDX)) begin
                    w_nextState = SORT;
                end
            end
            SORT: begin
                busy = 1'b1;
                if (w_lastPos && w_sortDone) begin
                    w_nextState = UNLOAD;
                end
            end
            UNLOAD: begin
                out_valid = 1'b1;
                out_data  = r_mem[r_rdIdx];
                w_outFire = out_ready;
                if (out_ready && (r_rdIdx == LAST_IDX)) begin
                    w_nextState = LOAD;
                end
            end
            default: begin
                w_nextState = LOAD;
            end
        endcase
    end

    // Both swapped entries are rewritten in the same cycle the compare resolves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrIdx   <= '0;
            r_rdIdx   <= '0;
            r_pass    <= '0;
            r_pos     <= '0;
            r_swapped <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_inFire) begin
                        r_mem[r_wrIdx] <= in_data;
                        if (r_wrIdx == LAST_IDX) begin
                            r_wrIdx   <= '0;
                            r_pass    <= '0;
                            r_pos     <= '0;
                            r_swapped <= 1'b0;
                        end else begin
                            r_wrIdx <= r_wrIdx + 1'b1;
                        end
                    end
                end
                SORT: begin
                    if (w_swap) begin
                        r_mem[r_pos]     <= w_b;
                        r_mem[w_posNext] <= w_a;
                    end
                    if (w_lastPos) begin
                        r_pos     <= '0;
                        r_pass    <= r_pass + 1'b1;
                        r_swapped <= 1'b0;
                        if (w_sortDone) begin
                            r_rdIdx <= '0;
                        end
                    end else begin
                        r_pos     <= r_pos + 1'b1;
                        r_swapped <= r_swapped | w_swap;
                    end
                end
                UNLOAD: begin
                    if (w_outFire) begin
                        if (r_rdIdx == LAST_IDX) begin
                            r_rdIdx <= '0;
                            r_wrIdx <= '0;
                        end else begin
                            r_rdIdx <= r_rdIdx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_sequencer.sv
// Testbench for sort_sequencer: directed frame table, reset-abort sequences, an
// exhaustive {0,5,10,15} sweep and random frames checked against a counting-sort model.
module tb_sort_sequencer;

    localparam int NB   = 4;
    localparam int D    = 4;
    localparam int FULL = D * (D - 1) / 2;
`ifdef SORT_EARLY_EXIT_EN
    localparam int SORTED_BUSY = D - 1;
    localparam int RAND_BUSY   = -1;
`else
    localparam int SORTED_BUSY = FULL;
    localparam int RAND_BUSY   = FULL;
`endif

    typedef logic [D*NB-1:0] frame_t;

    typedef struct packed {
        frame_t      din;
        frame_t      dexp;
        logic [15:0] pat;
        int          patLen;
        int          expBusy;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NB-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [NB-1:0] out_data;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int swapCount = 0;

    sort_sequencer #(
        .NUM_OF_BITS(NB),
        .DEPTH      (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Every exchange the sorter performs removes exactly one inversion.
    always @(negedge clk) begin
        if (busy === 1'b1 && dut.w_swap === 1'b1) begin
            swapCount++;
        end
    end

    function automatic frame_t mk(input int a, input int b, input int c, input int d);
        return {d[NB-1:0], c[NB-1:0], b[NB-1:0], a[NB-1:0]};
    endfunction

    // Reference: counting sort over the value range.
    function automatic frame_t sortRef(input frame_t f);
        int     cnt[16] = '{default: 0};
        int     k = 0;
        frame_t r = '0;
        for (int i = 0; i < D; i++) begin
            cnt[f[i*NB +: NB]]++;
        end
        for (int v = 0; v < 16; v++) begin
            for (int c = 0; c < cnt[v]; c++) begin
                r[k*NB +: NB] = v[NB-1:0];
                k++;
            end
        end
        return r;
    endfunction

    function automatic int inversions(input frame_t f);
        int n = 0;
        for (int i = 0; i < D; i++) begin
            for (int j = i + 1; j < D; j++) begin
                if (f[i*NB +: NB] > f[j*NB +: NB]) begin
                    n++;
                end
            end
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic loadFrame(input frame_t f, input string tag);
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            checkOutput($sformatf("%s in_ready word%0d", tag, i), 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = f[i*NB +: NB];
            out_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        checkOutput($sformatf("%s in_ready drop", tag), 32'(in_ready), 32'd0);
        checkOutput($sformatf("%s busy rise", tag), 32'(busy), 32'd1);
    endtask

    // Drives a whole frame; in_valid stays high with junk outside LOAD to prove it is ignored.
    task automatic applyStimulus(input frame_t f, input frame_t expOut, input logic [15:0] pat,
                                 input int patLen, input int expBusy, input string tag);
        int            n;
        int            cyc;
        int            nGot;
        frame_t        got;
        logic [NB-1:0] prevData;
        bit            stalled;
        swapCount = 0;
        got = '0;
        loadFrame(f, tag);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            in_data   = NB'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (expBusy >= 0) begin
            checkOutput($sformatf("%s busy cycles", tag), 32'(n), 32'(expBusy));
        end
        checkOutput($sformatf("%s out_valid rise", tag), 32'(out_valid), 32'd1);
        checkOutput($sformatf("%s swap count", tag), 32'(swapCount), 32'(inversions(f)));
        nGot = 0;
        cyc = 0;
        stalled = 1'b0;
        prevData = '0;
        while (nGot < D && cyc < 64) begin
            if (stalled) begin
                checkOutput($sformatf("%s stall hold", tag), 32'(out_data), 32'(prevData));
            end
            checkOutput($sformatf("%s in_ready low in unload", tag), 32'(in_ready), 32'd0);
            out_ready = (patLen == 0) ? 1'($urandom_range(0, 1)) : pat[cyc % patLen];
            in_data   = NB'($urandom);
            if (out_valid && out_ready) begin
                got[nGot*NB +: NB] = out_data;
                nGot++;
                stalled = 1'b0;
            end else begin
                stalled  = out_valid;
                prevData = out_data;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput($sformatf("%s words delivered", tag), 32'(nGot), 32'(D));
        if (patLen == 1 && pat[0]) begin
            checkOutput($sformatf("%s unload cycles", tag), 32'(cyc), 32'(D));
        end
        checkOutput($sformatf("%s out_valid drop", tag), 32'(out_valid), 32'd0);
        checkOutput($sformatf("%s back to load", tag), 32'(in_ready), 32'd1);
        for (int i = 0; i < D; i++) begin
            checkOutput($sformatf("%s out word%0d", tag, i), 32'(got[i*NB +: NB]), 32'(expOut[i*NB +: NB]));
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput($sformatf("%s in_ready", tag), 32'(in_ready), 32'd1);
        checkOutput($sformatf("%s out_valid", tag), 32'(out_valid), 32'd0);
        checkOutput($sformatf("%s busy", tag), 32'(busy), 32'd0);
        checkOutput($sformatf("%s out_data", tag), 32'(out_data), 32'd0);
    endtask

    initial begin
        vec_t   vecs[4];
        frame_t f;

        vecs[0] = '{mk(9, 3, 12, 0),   mk(0, 3, 9, 12),   16'h0001, 1, FULL};
        vecs[1] = '{mk(5, 5, 2, 5),    mk(2, 5, 5, 5),    16'h0001, 1, FULL};
        vecs[2] = '{mk(1, 2, 3, 4),    mk(1, 2, 3, 4),    16'h0001, 1, SORTED_BUSY};
        vecs[3] = '{mk(15, 14, 13, 12), mk(12, 13, 14, 15), 16'h0059, 7, FULL};

        repeat (2) @(negedge clk);
        checkIdle("in reset");
        rst = 1'b0;
        @(negedge clk);
        checkIdle("after reset");

        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].din, vecs[v].dexp, vecs[v].pat, vecs[v].patLen,
                          vecs[v].expBusy, $sformatf("vec%0d", v));
        end

        // Reset with a partial frame loaded.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'd7;
        @(negedge clk);
        in_data  = 4'd8;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkIdle("rst in load");

        // Reset in the middle of SORT.
        loadFrame(mk(3, 9, 1, 6), "rst sort");
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst sort still busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkIdle("rst in sort");

        applyStimulus(mk(7, 1, 4, 2), mk(1, 2, 4, 7), 16'h0001, 1, FULL, "post rst");

        for (int code = 0; code < 256; code++) begin
            f = mk(5 * (code & 3), 5 * ((code >> 2) & 3), 5 * ((code >> 4) & 3), 5 * ((code >> 6) & 3));
            applyStimulus(f, sortRef(f), 16'h0001, 1, RAND_BUSY, $sformatf("sweep%0d", code));
        end

        for (int r = 0; r < 24; r++) begin
            f = frame_t'($urandom);
            applyStimulus(f, sortRef(f), 16'h0000, 0, RAND_BUSY, $sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
